// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults, entry type and opcode helper for the fetch stage
package fetch_pkg;

  localparam int unsigned     INSN_W_DEF = 16;
  localparam int unsigned     ADDR_W_DEF = 16;
  localparam logic [1:0]      BR_OPC_DEF = 2'b01;
  localparam logic [INSN_W_DEF-1:0] NOP_DEF = '0;

  // Queue entry layout at the default widths; the top declares its own
  // parameter-sized copy with the same field order.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INSN_W_DEF-1:0] insn;
  } fetch_entry_t;

  // Two-bit opcode field at the top of an insn_w-wide instruction.
  // The instruction is passed zero-extended to 64 bits.
  function automatic logic [1:0] opc_field(input logic [63:0] insn, input int unsigned insn_w);
    logic [63:0] shifted;
    shifted = insn >> (insn_w - 2);
    return shifted[1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush and occupancy count
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the queue in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch stage: PC, branch park and prefetch queue
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       INSN_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [1:0]        BR_OPC   = BR_OPC_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSN_W-1:0] NOP      = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INSN_W-1:0] rom_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc,
  output logic              br_wait
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              is_br;
  entry_t            wr_entry;
  entry_t            head;
  logic [CNT_W-1:0]  q_count_unused;

  // A redirect cycle neither fetches nor consumes: the flush wins.
  assign rom_en   = !rst && !br_wait && !full && !redirect;
  assign rom_addr = pc;
  assign push     = rom_en;
  assign pop      = !empty && insn_ready && !redirect;
  assign is_br    = (opc_field(64'(rom_rdata), INSN_W) == BR_OPC);

  assign wr_entry.pc   = pc;
  assign wr_entry.insn = rom_rdata;

  assign insn_valid = !empty;
  assign insn       = insn_valid ? head.insn : NOP;
  assign insn_pc    = insn_valid ? head.pc   : '0;

  // PC advance and branch park; redirect reloads the PC and unparks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      br_wait <= 1'b0;
    end else if (redirect) begin
      pc      <= redirect_pc;
      br_wait <= 1'b0;
    end else if (push) begin
      pc <= pc + 1'b1;
      if (is_br) br_wait <= 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + INSN_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (q_count_unused)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [15:0] rom_rdata;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [15:0] insn;
  logic [15:0] insn_pc;
  logic        br_wait;

  logic        br_en = 1'b0;
  logic [15:0] br_addr = '0;

  logic        w_rst = 1'b1;
  logic        w_rom_en;
  logic [15:0] w_rom_addr;
  logic [15:0] w_rom_rdata;
  logic        w_redirect = 1'b0;
  logic [15:0] w_redirect_pc = '0;
  logic        w_insn_valid;
  logic        w_insn_ready = 1'b0;
  logic [15:0] w_insn;
  logic [15:0] w_insn_pc;
  logic        w_br_wait;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] sb [$];

  always_comb begin
    if (br_en && rom_addr == br_addr) rom_rdata = 16'h4ABC;
    else                              rom_rdata = 16'h1000 + {4'h0, rom_addr[11:0]};
  end

  always_comb w_rom_rdata = 16'h1000 + {4'h0, w_rom_addr[11:0]};

  fetch_queue_unit dut (
    .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc), .br_wait(br_wait)
  );

  fetch_queue_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(w_rst), .rom_en(w_rom_en), .rom_addr(w_rom_addr), .rom_rdata(w_rom_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc), .insn_valid(w_insn_valid),
    .insn_ready(w_insn_ready), .insn(w_insn), .insn_pc(w_insn_pc), .br_wait(w_br_wait)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    sb.delete();
    rst = 1'b1; insn_ready = 1'b0; br_en = 1'b1; br_addr = 16'h0001;
    tick(); tick();
    rst = 1'b0; #1;
    tick(); tick();
    total++; if (br_wait !== 1'b1) $display("FAIL reset_pre_br_wait: got %b want 1", br_wait); else passed++;
    total++; if (insn_valid !== 1'b1) $display("FAIL reset_pre_valid: got %b want 1", insn_valid); else passed++;
    rst = 1'b1; #1;
    total++; if (insn_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", insn_valid); else passed++;
    total++; if (insn !== 16'h0000) $display("FAIL reset_insn: got %h want 0000", insn); else passed++;
    total++; if (insn_pc !== 16'h0000) $display("FAIL reset_insn_pc: got %h want 0000", insn_pc); else passed++;
    total++; if (rom_addr !== 16'h0000) $display("FAIL reset_rom_addr: got %h want 0000", rom_addr); else passed++;
    total++; if (br_wait !== 1'b0) $display("FAIL reset_br_wait: got %b want 0", br_wait); else passed++;
    total++; if (rom_en !== 1'b0) $display("FAIL reset_rom_en: got %b want 0", rom_en); else passed++;
    br_en = 1'b0;
    tick();
  endtask

  task automatic test_straight_line();
    int first = -1;
    int last  = -1;
    logic [31:0] e;
    sb.delete();
    rst = 1'b1; insn_ready = 1'b1;
    tick();
    rst = 1'b0; #1;
    total++; if (insn_valid !== 1'b0) $display("FAIL straight_t0_valid: got %b want 0", insn_valid); else passed++;
    total++; if (rom_en !== 1'b1 || rom_addr !== 16'h0000) $display("FAIL straight_t0_fetch: got en=%b addr=%h want en=1 addr=0000", rom_en, rom_addr); else passed++;
    for (int p = 0; p < 4; p++) sb.push_back({16'(p), 16'h1000 + 16'(p)});
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (insn_valid && insn_ready && !redirect) begin
        e = sb.pop_front();
        if (first < 0) first = k;
        last = k;
        total++; if (insn !== e[15:0]) $display("FAIL straight_insn: got %h want %h", insn, e[15:0]); else passed++;
        total++; if (insn_pc !== e[31:16]) $display("FAIL straight_pc: got %h want %h", insn_pc, e[31:16]); else passed++;
      end
      tick();
    end
    total++; if (sb.size() != 0) $display("FAIL straight_timeout: got %0d left want 0", sb.size()); else passed++;
    total++; if (first != 1 || last != 4) $display("FAIL straight_timing: got first=%0d last=%0d want 1 4", first, last); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    sb.delete();
    rst = 1'b1; insn_ready = 1'b0;
    tick();
    rst = 1'b0; #1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k >= 4) begin
        total++; if (rom_en !== 1'b0) $display("FAIL full_rom_en: got %b want 0", rom_en); else passed++;
        total++; if (rom_addr !== 16'h0004) $display("FAIL full_rom_addr: got %h want 0004", rom_addr); else passed++;
      end
    end
    insn_ready = 1'b1; #1;
    for (int p = 0; p < 4; p++) sb.push_back({16'(p), 16'h1000 + 16'(p)});
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (insn_valid && insn_ready && !redirect) begin
        e = sb.pop_front();
        total++; if (insn !== e[15:0]) $display("FAIL drain_insn: got %h want %h", insn, e[15:0]); else passed++;
        total++; if (insn_pc !== e[31:16]) $display("FAIL drain_pc: got %h want %h", insn_pc, e[31:16]); else passed++;
      end
      tick();
    end
    total++; if (sb.size() != 0) $display("FAIL drain_timeout: got %0d left want 0", sb.size()); else passed++;
  endtask

  task automatic test_branch_park();
    logic [31:0] e;
    sb.delete();
    rst = 1'b1; insn_ready = 1'b0; br_en = 1'b1; br_addr = 16'h0002;
    tick();
    rst = 1'b0; #1;
    tick(); tick(); tick();
    total++; if (br_wait !== 1'b1) $display("FAIL br_wait_set: got %b want 1", br_wait); else passed++;
    total++; if (rom_en !== 1'b0) $display("FAIL br_rom_en: got %b want 0", rom_en); else passed++;
    insn_ready = 1'b1; #1;
    sb.push_back({16'h0000, 16'h1000});
    sb.push_back({16'h0001, 16'h1001});
    sb.push_back({16'h0002, 16'h4ABC});
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (insn_valid && insn_ready && !redirect) begin
        e = sb.pop_front();
        total++; if (insn !== e[15:0]) $display("FAIL br_insn: got %h want %h", insn, e[15:0]); else passed++;
        total++; if (insn_pc !== e[31:16]) $display("FAIL br_pc: got %h want %h", insn_pc, e[31:16]); else passed++;
      end
      tick();
    end
    total++; if (sb.size() != 0) $display("FAIL br_timeout: got %0d left want 0", sb.size()); else passed++;
    total++; if (insn_valid !== 1'b0) $display("FAIL br_no_pc3: got valid=%b want 0", insn_valid); else passed++;
    total++; if (rom_addr !== 16'h0003) $display("FAIL br_hold_addr: got %h want 0003", rom_addr); else passed++;
    redirect = 1'b1; redirect_pc = 16'h0010; #1;
    total++; if (rom_en !== 1'b0) $display("FAIL redir_rom_en: got %b want 0", rom_en); else passed++;
    tick();
    redirect = 1'b0; #1;
    total++; if (br_wait !== 1'b0) $display("FAIL redir_br_wait: got %b want 0", br_wait); else passed++;
    total++; if (rom_addr !== 16'h0010 || rom_en !== 1'b1) $display("FAIL redir_fetch: got en=%b addr=%h want en=1 addr=0010", rom_en, rom_addr); else passed++;
    total++; if (insn_valid !== 1'b0) $display("FAIL redir_empty: got %b want 0", insn_valid); else passed++;
    sb.push_back({16'h0010, 16'h1010});
    sb.push_back({16'h0011, 16'h1011});
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (insn_valid && insn_ready && !redirect) begin
        e = sb.pop_front();
        total++; if (insn !== e[15:0]) $display("FAIL redir_insn: got %h want %h", insn, e[15:0]); else passed++;
        total++; if (insn_pc !== e[31:16]) $display("FAIL redir_pc: got %h want %h", insn_pc, e[31:16]); else passed++;
      end
      tick();
    end
    total++; if (sb.size() != 0) $display("FAIL redir_timeout: got %0d left want 0", sb.size()); else passed++;
    br_en = 1'b0;
  endtask

  task automatic test_flush_with_pop();
    int first = -1;
    logic [31:0] e;
    sb.delete();
    rst = 1'b1; insn_ready = 1'b0;
    tick();
    rst = 1'b0; #1;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 16'h0020; insn_ready = 1'b1;
    tick();
    redirect = 1'b0; #1;
    total++; if (insn_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", insn_valid); else passed++;
    total++; if (rom_addr !== 16'h0020) $display("FAIL flush_rom_addr: got %h want 0020", rom_addr); else passed++;
    for (int p = 0; p < 3; p++) sb.push_back({16'h0020 + 16'(p), 16'h1020 + 16'(p)});
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (insn_valid && insn_ready && !redirect) begin
        e = sb.pop_front();
        if (first < 0) first = k;
        total++; if (insn !== e[15:0]) $display("FAIL flush_insn: got %h want %h", insn, e[15:0]); else passed++;
        total++; if (insn_pc !== e[31:16]) $display("FAIL flush_pc: got %h want %h", insn_pc, e[31:16]); else passed++;
      end
      tick();
    end
    total++; if (sb.size() != 0) $display("FAIL flush_timeout: got %0d left want 0", sb.size()); else passed++;
    total++; if (first != 1) $display("FAIL flush_first: got %0d want 1", first); else passed++;
  endtask

  task automatic test_pc_wrap();
    logic [31:0] e;
    sb.delete();
    w_rst = 1'b1; w_insn_ready = 1'b1;
    tick();
    w_rst = 1'b0; #1;
    total++; if (w_rom_addr !== 16'hFFFE) $display("FAIL wrap_start: got %h want fffe", w_rom_addr); else passed++;
    sb.push_back({16'hFFFE, 16'h1FFE});
    sb.push_back({16'hFFFF, 16'h1FFF});
    sb.push_back({16'h0000, 16'h1000});
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (w_insn_valid && w_insn_ready && !w_redirect) begin
        e = sb.pop_front();
        total++; if (w_insn !== e[15:0]) $display("FAIL wrap_insn: got %h want %h", w_insn, e[15:0]); else passed++;
        total++; if (w_insn_pc !== e[31:16]) $display("FAIL wrap_pc: got %h want %h", w_insn_pc, e[31:16]); else passed++;
      end
      tick();
    end
    total++; if (sb.size() != 0) $display("FAIL wrap_timeout: got %0d left want 0", sb.size()); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_straight_line();
    test_backpressure();
    test_branch_park();
    test_flush_with_pop();
    test_pc_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
